// File: rtl/irom_sram_reader.sv
// Fetch-side read controller for two parallel 16-bit async SRAMs. It runs a fixed-wait
// read cycle per word miss and returns the assembled 32-bit instruction with completion flags.
module irom_sram_reader #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_ce,
    input  logic [31:0]       irom_addr,
    output logic [31:0]       rom_inst,
    output logic              rfin_c,
    output logic              rfin_d,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    input  logic [15:0]       rdata_a,
    input  logic [15:0]       rdata_b,
    output logic [1:0]        dbg_state
);

    // Handshake: the fetch stage holds read_ce and irom_addr steady for the whole fetch;
    // the word is delivered in any cycle where rfin_c/rfin_d are high, and only for the
    // address presented in that same cycle (flags are combinational on read_ce and hit).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         inst_q, inst_d;

    logic [ADDR_W-1:0]   word_addr;
    logic                hit;
    logic                unused_bits;

    assign word_addr   = irom_addr[ADDR_W+1:2];
    assign hit         = (word_addr == addr_q);
    assign unused_bits = ^{irom_addr[1:0], irom_addr[31:ADDR_W+2]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        inst_d  = inst_q;
        case (state_q)
            IDLE: begin
                if (read_ce) begin
                    addr_d  = word_addr;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!read_ce) begin
                    state_d = IDLE;
                end else if (!hit) begin
                    // Retarget restarts the wait so a partial read is never captured.
                    addr_d = word_addr;
                    cnt_d  = 4'd0;
                end else if (cnt_q == LAST_CNT) begin
                    inst_d  = {rdata_b, rdata_a};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (!read_ce) begin
                    state_d = IDLE;
                end else if (!hit) begin
                    addr_d  = word_addr;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            inst_q  <= inst_d;
        end
    end

    // Strobes decode straight from the state flop so an async reset releases the SRAM at once.
    assign sram_ce_n = (state_q != ACCESS);
    assign sram_oe_n = (state_q != ACCESS);
    assign sram_we_n = 1'b1;
    assign sram_addr = addr_q;
    assign rom_inst  = inst_q;
    assign rfin_c    = (state_q == DONE) && read_ce && hit;
    assign rfin_d    = rfin_c;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_irom_sram_reader.sv
// Directed bench for irom_sram_reader: a run-length model of the fetch protocol is
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_irom_sram_reader;

    localparam int W  = 2;
    localparam int AW = 20;

    logic          clk;
    logic          rst;
    logic          read_ce;
    logic [31:0]   irom_addr;
    logic [31:0]   rom_inst;
    logic          rfin_c;
    logic          rfin_d;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [15:0]   rdata_a;
    logic [15:0]   rdata_b;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];

    irom_sram_reader #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .read_ce   (read_ce),
        .irom_addr (irom_addr),
        .rom_inst  (rom_inst),
        .rfin_c    (rfin_c),
        .rfin_d    (rfin_d),
        .sram_addr (sram_addr),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: valid data only while both strobes are low, garbage otherwise.
    assign rdata_a = (!sram_ce_n && !sram_oe_n) ? mem_a[sram_addr[3:0]] : 16'hDEAD;
    assign rdata_b = (!sram_ce_n && !sram_oe_n) ? mem_b[sram_addr[3:0]] : 16'hDEAD;

    // Model: m_run counts consecutive edges with read_ce high on the same word.
    // Edges 1..W are the SRAM wait, edge W+1 captures, beyond that the word is held.
    int            m_run;
    logic [AW-1:0] m_word;
    logic [31:0]   m_inst;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run  <= 0;
            m_word <= '0;
            m_inst <= '0;
        end else if (read_ce) begin
            if (m_run > 0 && irom_addr[AW+1:2] == m_word) begin
                m_run <= (m_run > 50) ? m_run : m_run + 1;
                if (m_run + 1 == W + 1)
                    m_inst <= {mem_b[m_word[3:0]], mem_a[m_word[3:0]]};
            end else begin
                m_run  <= 1;
                m_word <= irom_addr[AW+1:2];
            end
        end else begin
            m_run <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic exp_fin;
        logic exp_ce_n;
        exp_fin  = read_ce && (irom_addr[AW+1:2] == m_word) && (m_run >= W + 1);
        exp_ce_n = !(m_run >= 1 && m_run <= W);
        chk("rfin_c", {31'd0, rfin_c}, {31'd0, exp_fin});
        chk("rfin_d", {31'd0, rfin_d}, {31'd0, exp_fin});
        chk("ce_n", {31'd0, sram_ce_n}, {31'd0, exp_ce_n});
        chk("oe_n", {31'd0, sram_oe_n}, {31'd0, exp_ce_n});
        chk("we_n", {31'd0, sram_we_n}, 32'd1);
        chk("sram_addr", {12'd0, sram_addr}, {12'd0, m_word});
        chk("rom_inst", rom_inst, m_inst);
    endtask

    // Driver: apply inputs on the falling edge, then compare against the model.
    task automatic step(input logic ce, input logic [31:0] addr);
        @(negedge clk);
        read_ce   = ce;
        irom_addr = addr;
        #2;
        check_model();
    endtask

    int access_cycles;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 16'(i * 16'h0101);
            mem_b[i] = 16'(16'hF000 | i);
        end
        mem_a[4] = 16'h5678; mem_b[4] = 16'h1234;
        mem_a[5] = 16'hBEEF; mem_b[5] = 16'hCAFE;
        mem_a[8] = 16'h1111; mem_b[8] = 16'h8888;
        mem_a[9] = 16'h2222; mem_b[9] = 16'h9999;

        rst       = 1'b0;
        read_ce   = 1'b0;
        irom_addr = 32'd0;
        step(0, 32'd0);
        chk("reset_inst", rom_inst, 32'd0);
        chk("reset_ce_n", {31'd0, sram_ce_n}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        step(0, 32'd0);

        // Reset asserted in the middle of an ACCESS cycle.
        step(1, 32'h40);
        @(posedge clk);
        #3;
        chk("mid_access_ce_n", {31'd0, sram_ce_n}, 32'd0);
        rst = 1'b0;
        #1;
        chk("async_rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("async_rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        step(0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 32'd0);
        chk("post_rst_rfin", {31'd0, rfin_c}, 32'd0);
        chk("post_rst_inst", rom_inst, 32'd0);

        // Single miss at word 4.
        access_cycles = 0;
        step(1, 32'h10);
        for (int i = 0; i < 2; i++) begin
            step(1, 32'h10);
            if (!sram_ce_n) access_cycles++;
            chk("miss_addr", {12'd0, sram_addr}, 32'h4);
        end
        chk("miss_access_cycles", access_cycles, 32'd2);
        step(1, 32'h10);
        chk("miss_inst", rom_inst, 32'h1234_5678);
        chk("miss_rfin", {30'd0, rfin_d, rfin_c}, 32'd3);

        // Repeat hit on the same word via a different byte offset.
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h13);
            chk("hit_rfin", {31'd0, rfin_c}, 32'd1);
            chk("hit_ce_n", {31'd0, sram_ce_n}, 32'd1);
        end

        // Address change in DONE: flags drop in the same cycle.
        step(1, 32'h14);
        chk("chg_rfin_same_cycle", {31'd0, rfin_c}, 32'd0);
        step(1, 32'h14);
        chk("chg_sram_addr", {12'd0, sram_addr}, 32'h5);
        step(1, 32'h14);
        step(1, 32'h14);
        chk("chg_inst", rom_inst, 32'hCAFE_BEEF);
        chk("chg_rfin", {31'd0, rfin_c}, 32'd1);

        // Abort after one ACCESS cycle.
        step(1, 32'h20);
        step(1, 32'h20);
        step(0, 32'h20);
        step(0, 32'h20);
        chk("abort_inst", rom_inst, 32'hCAFE_BEEF);
        chk("abort_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("abort_rfin", {31'd0, rfin_c}, 32'd0);

        // Retarget on the first ACCESS cycle: only word 9 may be captured.
        step(1, 32'h20);
        step(1, 32'h24);
        step(1, 32'h24);
        chk("retarget_pending", {31'd0, rfin_c}, 32'd0);
        step(1, 32'h24);
        chk("retarget_wait", {31'd0, rfin_c}, 32'd0);
        step(1, 32'h24);
        chk("retarget_inst", rom_inst, 32'h9999_2222);
        chk("retarget_rfin", {31'd0, rfin_c}, 32'd1);

        // Drop and address change together: the drop wins.
        step(0, 32'h30);
        step(0, 32'h30);
        chk("drop_wins_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("drop_wins_inst", rom_inst, 32'h9999_2222);

        // Fresh request to word 12 after idle, then a few idle cycles.
        for (int i = 0; i < 4; i++) step(1, 32'h30);
        chk("fresh_inst", rom_inst, {16'hF00C, 16'h0C0C});
        for (int i = 0; i < 2; i++) step(0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irom_sram_reader.md
# irom_sram_reader

Fetch-side SRAM read controller that sits directly downstream of the instruction-fetch port. It accepts a word-read request (`read_ce`, `irom_addr`) and runs a fixed-wait read cycle on two parallel 16-bit asynchronous SRAM chips that share address and control lines. It assembles the 32-bit instruction and returns it on `rom_inst` with completion flags `rfin_c`/`rfin_d`. The fetch stage consumes the instruction only while both flags are high.

## Interface
- `WAIT_CYCLES`, default 2: cycles with `sram_oe_n` low before data is sampled; legal range 1..15.
- `ADDR_W`, default 20: SRAM word-address width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `read_ce` in 1: read request, held high for the whole fetch.
- `irom_addr` in 32: byte address. Bits [1:0] are ignored; the word address is `irom_addr[ADDR_W+1:2]`; higher bits are ignored.
- `rom_inst` out 32: assembled instruction `{rdata_b, rdata_a}`.
- `rfin_c` out 1: read complete, chip-a half valid.
- `rfin_d` out 1: read complete, chip-b half valid. Always equal to `rfin_c`.
- `sram_addr` out ADDR_W: shared SRAM word address.
- `sram_ce_n` out 1: shared chip enable, active-low.
- `sram_oe_n` out 1: shared output enable, active-low.
- `sram_we_n` out 1: write enable, active-low; held 1 (read-only).
- `rdata_a` in 16: chip-a data, low half-word.
- `rdata_b` in 16: chip-b data, high half-word.

## Operation
- Registers:
  - `state` ∈ {IDLE, ACCESS, DONE}
  - `addr_q` [ADDR_W-1:0]
  - `cnt` [3:0]
  - `rom_inst` [31:0]
- `hit` = (`irom_addr[ADDR_W+1:2]` == `addr_q`).
- IDLE:
  - `sram_ce_n` = `sram_oe_n` = 1.
  - If `read_ce`=1: `addr_q` ← word address, `cnt` ← 0, go to ACCESS.
- ACCESS:
  - `sram_ce_n` = `sram_oe_n` = 0; `sram_addr` = `addr_q`.
  - If `read_ce`=0: go to IDLE with no capture; `rom_inst` is unchanged.
  - Else if `hit`=0 (address changed mid-read): `addr_q` ← new word address, `cnt` ← 0, stay in ACCESS.
  - Else if `cnt` == WAIT_CYCLES-1: `rom_inst` ← {`rdata_b`, `rdata_a`}, go to DONE.
  - Else `cnt` ← `cnt`+1.
- DONE:
  - `sram_ce_n` = `sram_oe_n` = 1; `rom_inst` is held.
  - If `read_ce`=0: go to IDLE (`rom_inst` retained).
  - Else if `hit`=0: `addr_q` ← new word address, `cnt` ← 0, go to ACCESS.
  - Else stay in DONE. A repeated fetch of the same word costs no SRAM access.
- `rfin_c` = `rfin_d` = (state==DONE) & `read_ce` & `hit`.
  - This is combinational, so a new address never sees stale data flagged complete in the same cycle.
- `sram_addr` is driven from `addr_q` in all states.
- `sram_we_n` is constant 1.

## Timing
- Reset (async assert, sync-safe deassert handled upstream):
  - state = IDLE; `addr_q`, `cnt`, `rom_inst` = 0.
  - `sram_ce_n` = `sram_oe_n` = `sram_we_n` = 1; `rfin_c` = `rfin_d` = 0.
- Reset asserted mid-ACCESS releases the SRAM (ce_n/oe_n high) immediately, without waiting for a clock edge.
- Miss latency, with the request sampled at edge E0:
  - ACCESS occupies cycles E0..E0+WAIT_CYCLES.
  - Data is captured at edge E0+WAIT_CYCLES.
  - Flags go high after that edge.
  - With WAIT_CYCLES=2: 3 cycles from request to `rfin`.
- Hit latency: 0 cycles; flags stay high while `read_ce` and the address are stable.
- Data sampled on the last ACCESS edge must have been driven by the SRAM for at least WAIT_CYCLES clock periods after `sram_addr` settled.
- Address change and `read_ce` drop in the same cycle: the drop wins and the block goes to IDLE.
- An address change between ACCESS and DONE restarts the count; an earlier partial read is never captured.

## Test plan
- Reset mid-access: reset asserted with state=ACCESS -> `sram_ce_n`=`sram_oe_n`=1 immediately; after release, `rfin`=0 and `rom_inst`=0.
- Single miss, WAIT_CYCLES=2:
  - Stimulus: `read_ce`=1, `irom_addr`=0x0000_0010, `rdata_a`=0x5678, `rdata_b`=0x1234.
  - `sram_addr`=0x00004 with ce_n/oe_n low for 2 cycles; `rom_inst`=0x1234_5678 and `rfin_c`=`rfin_d`=1 on the 3rd cycle.
- Repeat hit: hold the request above, then change `irom_addr` to 0x0000_0013 (same word) -> flags stay 1, no new SRAM cycle (ce_n stays 1).
- Address change in DONE: `irom_addr` 0x10 → 0x14 -> flags drop to 0 in the same cycle, `sram_addr`=0x00005; new data is returned 3 cycles later.
- Abort mid-ACCESS: drop `read_ce` after 1 ACCESS cycle -> IDLE, `rom_inst` keeps its prior value, flags 0, ce_n/oe_n=1 on the next cycle.
- Retarget mid-ACCESS: change the address on cycle 1 of ACCESS -> `cnt` restarts; only the second address's data is captured, a full WAIT_CYCLES after the change.
